// File: rtl/count_ctrl.sv
// count_ctrl: button-driven start/pause/clear controller for a downstream 4-bit counter.
// Build option: define AUTO_RELOAD_EN to make terminal count restart the counter instead of entering DONE.
module count_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] limit,
  input  logic [3:0] count,
  output logic       counten,
  output logic       clr,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

  state_t     state_r;
  logic [7:0] div_cnt_r;
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] prev_r;
  logic       clr_r;
  logic       done_r;

  logic       start_ev_s;
  logic       stop_ev_s;
  logic       clear_ev_s;
  logic       div_last_s;
  logic [7:0] div_next_s;
  logic [3:0] count_eff_s;
  logic       at_limit_s;
  logic       counten_s;

  // Button edge events, prescaler next value and terminal-count decode.
  // While clr is high the counter is being zeroed, so its feedback is treated as 0.
  always_comb begin
    start_ev_s = sync2_r[0] & ~prev_r[0];
    stop_ev_s  = sync2_r[1] & ~prev_r[1];
    clear_ev_s = sync2_r[2] & ~prev_r[2];
    div_last_s = (div_cnt_r == DIV_LAST);
    if (div_last_s) begin
      div_next_s = 8'd0;
    end else begin
      div_next_s = div_cnt_r + 8'd1;
    end
    if (clr_r) begin
      count_eff_s = 4'd0;
    end else begin
      count_eff_s = count;
    end
    at_limit_s = (count_eff_s == limit);
    counten_s  = (state_r == RUN) & div_last_s & (count != limit);
  end

  // Synchronizers, control FSM, prescaler and registered clr/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      div_cnt_r <= 8'd0;
      sync1_r   <= 3'b000;
      sync2_r   <= 3'b000;
      prev_r    <= 3'b000;
      clr_r     <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      sync1_r <= {clear, stop, start};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      clr_r   <= 1'b0;
      if (clear_ev_s) begin
        state_r   <= IDLE;
        div_cnt_r <= 8'd0;
        clr_r     <= 1'b1;
        done_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            done_r <= 1'b0;
            if (start_ev_s) begin
              state_r   <= RUN;
              div_cnt_r <= 8'd0;
            end
          end
          RUN: begin
            if (stop_ev_s) begin
              state_r   <= PAUSE;
              div_cnt_r <= div_next_s;
              done_r    <= 1'b0;
            end else if (at_limit_s) begin
`ifdef AUTO_RELOAD_EN
              clr_r     <= 1'b1;
              done_r    <= 1'b1;
              div_cnt_r <= 8'd0;
`else
              state_r   <= DONE;
              done_r    <= 1'b1;
`endif
            end else begin
              div_cnt_r <= div_next_s;
              done_r    <= 1'b0;
            end
          end
          PAUSE: begin
            done_r <= 1'b0;
            if (start_ev_s) begin
              state_r <= RUN;
            end
          end
          DONE: begin
            if (start_ev_s) begin
              state_r   <= RUN;
              clr_r     <= 1'b1;
              div_cnt_r <= 8'd0;
              done_r    <= 1'b0;
            end else begin
              done_r <= 1'b1;
            end
          end
          default: begin
            state_r   <= IDLE;
            div_cnt_r <= 8'd0;
            done_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign counten = counten_s;
  assign clr     = clr_r;
  assign done    = done_r;
  assign state   = state_r;

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, giving clock cycles per counten pulse while running; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: raw start/resume button, asynchronous to clk.
REQ-005 SHALL have port stop, input, 1 bit: raw pause button, asynchronous to clk.
REQ-006 SHALL have port clear, input, 1 bit: raw clear button, asynchronous to clk.
REQ-007 SHALL have port limit, input, 4 bits: terminal count value, sampled every cycle.
REQ-008 SHALL have port count, input, 4 bits: feedback from the downstream 4-bit counter's count.
REQ-009 SHALL have port counten, output, 1 bit: drives the downstream counter's counten.
REQ-010 SHALL have port clr, output, 1 bit, registered: drives the downstream counter's synchronous reset.
REQ-011 SHALL have port done, output, 1 bit: terminal-count indication.
REQ-012 SHALL have port state, output, 2 bits: current FSM state.

Function
REQ-013 SHALL pass each button through a two-flop synchronizer plus a previous-value flop; event = sync2 & ~prev, so each press yields exactly one event.
REQ-014 SHALL register the FSM transition caused by a button on the second rising edge after the edge where the button is first sampled high.
REQ-015 SHALL implement states IDLE=00, RUN=01, PAUSE=10, DONE=11 on the state port.
REQ-016 SHALL apply event priority clear > stop > start when several events coincide in one cycle.
REQ-017 Clear event in any state: SHALL go to IDLE and assert clr for exactly one cycle.
REQ-018 IDLE + start: go to RUN; DONE + start: go to RUN and assert clr for one cycle; PAUSE + start: go to RUN; start in RUN is ignored.
REQ-019 RUN + stop: go to PAUSE; stop in any other state is ignored.
REQ-020 SHALL keep an 8-bit prescaler div_cnt counting 0..TICK_DIV-1 and wrapping, advancing only in RUN, holding in PAUSE, and cleared to 0 on entry to RUN from IDLE or DONE.
REQ-021 counten SHALL equal (state==RUN) & (div_cnt==TICK_DIV-1) & (count!=limit), decoded from registered state only; never high outside RUN.
REQ-022 In RUN with count==limit (clear and stop absent), the FSM SHALL take the terminal action (REQ-027) on the next edge.
REQ-023 limit==0 with count==0 in RUN SHALL take the terminal action on the first RUN cycle, with counten never asserted.
REQ-024 limit lowered below the current count in RUN: counting SHALL continue, with the 4-bit counter wrapping 15->0, until count==limit.
REQ-025 done SHALL be a registered level, high exactly while in DONE (macro absent).

Reset
REQ-026 While reset is high at a clock edge: state=IDLE, div_cnt=0, synchronizer and previous-value flops=0, done=0, counten=0, clr=1; clr SHALL fall on the first edge with reset low. Reset mid-RUN SHALL abort the run with no counten pulse.

Configuration
REQ-027 Macro AUTO_RELOAD_EN. Absent: the terminal action moves RUN->DONE and holds done high. Defined: the FSM stays in RUN, asserts clr and done for exactly one cycle, and restarts div_cnt at 0; state 11 is then unreachable.

Verification
REQ-028 Reset for 3 cycles, then release -> state=00, counten=0, done=0, clr=1 during reset and 0 one cycle after.
REQ-029 TICK_DIV=4, limit=5, start pressed from IDLE with a counter model attached -> 5 counten pulses spaced exactly 4 cycles apart, count reaches 5, then state=11, done=1.
REQ-030 Mid-run: stop at count=2, hold 10 cycles, then start -> state 01->10->01, no counten while 10, div_cnt phase preserved, run completes at count=5.
REQ-031 start, stop and clear rising in the same cycle during RUN -> state=00, clr high for exactly 1 cycle, count=0.
REQ-032 limit=0, then start -> state goes 01 then 11 with zero counten pulses; with AUTO_RELOAD_EN defined -> done and clr pulse each cycle while state stays 01.
REQ-033 AUTO_RELOAD_EN defined, limit=3, TICK_DIV=4 -> count sequence 0,1,2,3,0,1,... with a 1-cycle done pulse per wrap.
